// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, legality check,
// arbiter FSM states and the registered op bundle.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRLV = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_ORI  = 4'b1010;
  localparam logic [3:0] ALU_EQ   = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ctrl;
    logic [4:0]  shamt;
    logic [15:0] imm;
  } alu_op_t;

  function automatic logic alu_ctrl_legal(input logic [3:0] c);
    logic ok;
    ok = 1'b0;
    case (c)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_NOR, ALU_NAND, ALU_SLT, ALU_SLL,
      ALU_SRLV, ALU_LUI, ALU_ORI, ALU_EQ: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after the last grant,
// returned as a one-hot vector plus its index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  int   k;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last) + i) % NREQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between NREQ
// requesters: grant, execute, then hold the response.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*DATA_W-1:0] req_src1_i,
  input  logic [NREQ*DATA_W-1:0] req_src2_i,
  input  logic [NREQ*4-1:0]    req_ctrl_i,
  input  logic [NREQ*5-1:0]    req_shamt_i,
  input  logic [NREQ*16-1:0]   req_imm_i,
  output logic [DATA_W-1:0]    alu_src1_o,
  output logic [DATA_W-1:0]    alu_src2_o,
  output logic [3:0]           alu_ctrl_o,
  output logic [4:0]           alu_shamt_o,
  output logic [15:0]          alu_imm_o,
  input  logic [DATA_W-1:0]    alu_result_i,
  input  logic                 alu_zero_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  input  logic [NREQ-1:0]      rsp_ready_i,
  output logic [DATA_W-1:0]    rsp_result_o,
  output logic                 rsp_zero_o,
  output logic                 rsp_err_o,
  output logic                 busy_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, id_q, gnt_idx;
  logic [NREQ-1:0] gnt, id_oh;
  logic [31:0]     sel;
  alu_op_t         op_q, op_sel;
  logic [31:0]     res_q;
  logic            zero_q, err_q;
  logic            take, rsp_hs;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req  (req_valid_i),
    .last (last_q),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  assign sel = 32'(gnt_idx);

  assign op_sel.src1  = req_src1_i[sel*32 +: 32];
  assign op_sel.src2  = req_src2_i[sel*32 +: 32];
  assign op_sel.ctrl  = req_ctrl_i[sel*4 +: 4];
  assign op_sel.shamt = req_shamt_i[sel*5 +: 5];
  assign op_sel.imm   = req_imm_i[sel*16 +: 16];

  assign take   = (state_q == ST_IDLE) && (|req_valid_i);
  assign rsp_hs = (state_q == ST_RESP) && rsp_ready_i[id_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (take) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // last_q starts at NREQ-1 so requester 0 wins first after reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      last_q <= IW'(NREQ - 1);
      id_q   <= '0;
      op_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (take) begin
        op_q <= op_sel;
        id_q <= gnt_idx;
      end
      if (state_q == ST_EXEC) begin
        res_q  <= alu_result_i;
        zero_q <= alu_zero_i;
        err_q  <= !alu_ctrl_legal(op_q.ctrl);
      end
      if (rsp_hs) last_q <= id_q;
    end
  end

  always_comb begin
    id_oh       = '0;
    id_oh[id_q] = 1'b1;
  end

  assign req_ready_o = (rst_i && state_q == ST_IDLE) ? gnt : '0;
  assign rsp_valid_o = (state_q == ST_RESP) ? id_oh : '0;

  assign alu_src1_o  = (state_q == ST_EXEC) ? op_q.src1  : '0;
  assign alu_src2_o  = (state_q == ST_EXEC) ? op_q.src2  : '0;
  assign alu_ctrl_o  = (state_q == ST_EXEC) ? op_q.ctrl  : '0;
  assign alu_shamt_o = (state_q == ST_EXEC) ? op_q.shamt : '0;
  assign alu_imm_o   = (state_q == ST_EXEC) ? op_q.imm   : '0;

  assign rsp_result_o = res_q;
  assign rsp_zero_o   = zero_q;
  assign rsp_err_o    = err_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench: reference ALU behind the bus, transaction-level
// model checked every cycle, directed and random traffic.
module tb_alu_share_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid_i, req_ready_o;
  logic [N*32-1:0] req_src1_i, req_src2_i;
  logic [N*4-1:0]  req_ctrl_i;
  logic [N*5-1:0]  req_shamt_i;
  logic [N*16-1:0] req_imm_i;
  logic [31:0]     alu_src1_o, alu_src2_o;
  logic [3:0]      alu_ctrl_o;
  logic [4:0]      alu_shamt_o;
  logic [15:0]     alu_imm_o;
  logic [31:0]     alu_result_i;
  logic            alu_zero_i;
  logic [N-1:0]    rsp_valid_o, rsp_ready_i;
  logic [31:0]     rsp_result_o;
  logic            rsp_zero_o, rsp_err_o, busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(N), .DATA_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_src1_i   (req_src1_i),
    .req_src2_i   (req_src2_i),
    .req_ctrl_i   (req_ctrl_i),
    .req_shamt_i  (req_shamt_i),
    .req_imm_i    (req_imm_i),
    .alu_src1_o   (alu_src1_o),
    .alu_src2_o   (alu_src2_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_shamt_o  (alu_shamt_o),
    .alu_imm_o    (alu_imm_o),
    .alu_result_i (alu_result_i),
    .alu_zero_i   (alu_zero_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_zero_o   (rsp_zero_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o)
  );

  // {err, result}
  function automatic logic [32:0] ref_alu(
    input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
    input logic [4:0] sh, input logic [15:0] im);
    logic [31:0] r;
    logic e;
    e = 1'b0;
    r = '0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b1100: r = ~(a | b);
      4'b1101: r = ~(a & b);
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = b << sh;
      4'b0100: r = b >> a[4:0];
      4'b1001: r = {im, 16'h0000};
      4'b1010: r = a | {16'h0000, im};
      4'b1011: r = (a == b) ? 32'd1 : 32'd0;
      default: begin r = '0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  logic [32:0] alu_out;
  assign alu_out = ref_alu(alu_ctrl_o, alu_src1_o, alu_src2_o,
                           alu_shamt_o, alu_imm_o);
  assign alu_result_i = alu_out[31:0];
  assign alu_zero_i   = (alu_out[31:0] == 32'd0);

  task automatic cmp(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++)
      if (v[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // model: at most one transaction in flight, age 0 = on ALU, 1 = response
  bit          m_init = 1'b0;
  bit          m_active = 1'b0;
  int          m_id = 0, m_age = 0, m_last = N - 1;
  logic [31:0] m_s1, m_s2;
  logic [3:0]  m_c;
  logic [4:0]  m_sh;
  logic [15:0] m_im;
  logic [N-1:0] n_acc = '0;
  int          n_pick = -1;

  always @(negedge clk) begin : compare
    logic [N-1:0] er, ev;
    logic [88:0]  ea;
    logic [32:0]  r;
    if (m_init) begin
      n_pick = rr_pick(req_valid_i, m_last);
      er = '0;
      if (rst_i && !m_active && n_pick >= 0) er[n_pick] = 1'b1;
      n_acc = er & req_valid_i;
      cmp("req_ready", 96'(req_ready_o), 96'(er));
      cmp("busy", 96'(busy_o), 96'(m_active));
      ea = (m_active && m_age == 0) ? {m_s1, m_s2, m_c, m_sh, m_im} : '0;
      cmp("alu_bus", 96'({alu_src1_o, alu_src2_o, alu_ctrl_o,
                          alu_shamt_o, alu_imm_o}), 96'(ea));
      ev = '0;
      if (m_active && m_age == 1) ev[m_id] = 1'b1;
      cmp("rsp_valid", 96'(rsp_valid_o), 96'(ev));
      if (ev != '0) begin
        r = ref_alu(m_c, m_s1, m_s2, m_sh, m_im);
        cmp("rsp_result", 96'(rsp_result_o), 96'(r[31:0]));
        cmp("rsp_zero", 96'(rsp_zero_o), 96'(r[31:0] == 32'd0));
        cmp("rsp_err", 96'(rsp_err_o), 96'(r[32]));
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_i) begin
      m_init   <= 1'b1;
      m_active <= 1'b0;
      m_last   <= N - 1;
    end else if (m_init) begin
      if (!m_active) begin
        if (n_acc != '0) begin
          m_active <= 1'b1;
          m_age    <= 0;
          m_id     <= n_pick;
          m_s1     <= req_src1_i[32*n_pick +: 32];
          m_s2     <= req_src2_i[32*n_pick +: 32];
          m_c      <= req_ctrl_i[4*n_pick +: 4];
          m_sh     <= req_shamt_i[5*n_pick +: 5];
          m_im     <= req_imm_i[16*n_pick +: 16];
        end
      end else if (m_age == 0) begin
        m_age <= 1;
      end else if (rsp_ready_i[m_id]) begin
        m_active <= 1'b0;
        m_last   <= m_id;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [3:0] c,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [15:0] im);
    req_src1_i[32*k +: 32] = a;
    req_src2_i[32*k +: 32] = b;
    req_ctrl_i[4*k +: 4]   = c;
    req_shamt_i[5*k +: 5]  = sh;
    req_imm_i[16*k +: 16]  = im;
    req_valid_i[k]         = 1'b1;
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!req_ready_o[k] && n < 20);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (rsp_valid_o == '0 && n < 20);
  endtask

  // called at posedge+1 with the DUT idle; leaves it idle again
  task automatic do_op(input string nm, input int k, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [15:0] im,
                       input logic [31:0] xr, input logic xz, input logic xe);
    logic [N-1:0] oh;
    int n;
    oh = '0;
    oh[k] = 1'b1;
    send(k, c, a, b, sh, im);
    rsp_ready_i = '1;
    wait_ready(k);
    cmp({nm, "_grant"}, 96'(req_ready_o), 96'(oh));
    step();
    req_valid_i[k] = 1'b0;
    wait_rsp(n);
    cmp({nm, "_latency"}, 96'(n), 96'd2);
    cmp({nm, "_valid"}, 96'(rsp_valid_o), 96'(oh));
    cmp({nm, "_result"}, 96'(rsp_result_o), 96'(xr));
    cmp({nm, "_zero"}, 96'(rsp_zero_o), 96'(xz));
    cmp({nm, "_err"}, 96'(rsp_err_o), 96'(xe));
    step();
  endtask

  initial begin
    int n;
    rst_i       = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = '0;
    req_src1_i  = '0;
    req_src2_i  = '0;
    req_ctrl_i  = '0;
    req_shamt_i = '0;
    req_imm_i   = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;

    @(negedge clk);
    cmp("reset_busy", 96'(busy_o), 96'd0);
    cmp("reset_rsp_valid", 96'(rsp_valid_o), 96'd0);
    cmp("reset_result", 96'({rsp_result_o, rsp_zero_o, rsp_err_o}), 96'd0);
    step();

    // idle bus stays quiet
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmp("idle_quiet", 96'({busy_o, req_ready_o, alu_src1_o, alu_src2_o,
                             alu_ctrl_o, alu_shamt_o, alu_imm_o}), 96'd0);
      step();
    end

    do_op("add", 0, 4'b0010, 32'd5, 32'd7, 5'd0, 16'd0, 32'd12, 1'b0, 1'b0);

    // alternating grants after a fresh reset
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    send(0, 4'b0110, 32'd9, 32'd9, 5'd0, 16'd0);
    send(1, 4'b1001, 32'd0, 32'd0, 5'd0, 16'h1234);
    rsp_ready_i = '1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end
      while (req_ready_o == '0 && n < 20);
      cmp("rr_grant", 96'(req_ready_o), (i % 2 == 1) ? 96'd2 : 96'd1);
      wait_rsp(n);
      if (i % 2 == 0) begin
        cmp("rr_sub_result", 96'({rsp_result_o, rsp_zero_o}), 96'd1);
      end else begin
        cmp("rr_lui_result", 96'({rsp_result_o, rsp_zero_o}),
            96'({32'h12340000, 1'b0}));
      end
      step();
    end
    req_valid_i = '0;

    // held response, wrong-requester ready ignored
    send(1, 4'b0011, 32'd0, 32'd1, 5'd31, 16'd0);
    rsp_ready_i = '0;
    wait_ready(1);
    cmp("hold_grant", 96'(req_ready_o), 96'd2);
    step();
    req_valid_i[1] = 1'b0;
    send(0, 4'b0001, 32'h0000_00F0, 32'h0000_000F, 5'd0, 16'd0);
    rsp_ready_i = 2'b01;
    wait_rsp(n);
    for (int j = 0; j < 5; j++) begin
      cmp("hold_valid", 96'(rsp_valid_o), 96'd2);
      cmp("hold_result", 96'(rsp_result_o), 96'h8000_0000);
      cmp("hold_no_grant", 96'(req_ready_o), 96'd0);
      @(negedge clk);
    end
    step();
    rsp_ready_i = 2'b10;
    wait_ready(0);
    cmp("after_hold_grant", 96'(req_ready_o), 96'd1);
    step();
    req_valid_i[0] = 1'b0;
    rsp_ready_i = '1;
    wait_rsp(n);
    cmp("after_hold_result", 96'(rsp_result_o), 96'h0000_00FF);
    step();

    do_op("bad_ctrl", 0, 4'b1111, 32'd3, 32'd4, 5'd0, 16'd0, 32'd0, 1'b1, 1'b1);
    do_op("slt", 0, 4'b0111, 32'd3, 32'd4, 5'd0, 16'd0, 32'd1, 1'b0, 1'b0);
    do_op("nor", 1, 4'b1100, 32'd0, 32'd0, 5'd0, 16'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // reset in the middle of an op
    send(0, 4'b1010, 32'd0, 32'd0, 5'd0, 16'hFFFF);
    rsp_ready_i = '1;
    wait_ready(0);
    step();
    req_valid_i[0] = 1'b0;
    rst_i = 1'b0;
    @(negedge clk);
    cmp("mid_reset_busy", 96'(busy_o), 96'd1);
    step();
    rst_i = 1'b1;
    send(1, 4'b0010, 32'd1, 32'd1, 5'd0, 16'd0);
    send(0, 4'b0010, 32'd1, 32'd2, 5'd0, 16'd0);
    @(negedge clk);
    cmp("post_reset_rsp", 96'(rsp_valid_o), 96'd0);
    cmp("post_reset_grant", 96'(req_ready_o), 96'd1);
    step();
    req_valid_i = '0;
    wait_rsp(n);
    cmp("post_reset_valid", 96'(rsp_valid_o), 96'd1);
    cmp("post_reset_result", 96'(rsp_result_o), 96'd3);
    step();

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (n_acc[k]) req_valid_i[k] = 1'b0;
        if (!req_valid_i[k] && $urandom_range(0, 2) == 0) begin
          send(k, 4'($urandom),
               ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3)),
               5'($urandom), 16'($urandom));
        end
      end
      rsp_ready_i = N'($urandom);
      rst_i = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_i = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = '1;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
